video_timing: RTL and testbench

Raster timing generator for the LCD video path. It divides `clk` into a pixel clock enable and runs horizontal and vertical counters. From those counters it decodes sync, data-enable, blanking and pixel coordinates. Its `hblank_int`, `vblank_int`, `video_x` and `video_y` outputs feed the LCD segment stage, which caches segment state on the `vblank_int` rising edge and uses the coordinates for mask lookup.

---
 rtl/video_timing.sv | 125 ++++++++++++
 tb/tb_video_timing.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// Raster timing generator: divides clk into a pixel enable, runs horizontal and
// vertical counters, and decodes sync, data enable, blanking and coordinates.
// Every output is registered and lags the counter state by one clk.
//
// Ports:
//   clk          sole clock
//   reset_n      asynchronous active-low reset
//   restart      synchronous restart of divider and both counters
//   ce_pix       one-clk pulse per pixel
//   hsync/vsync  active-high sync
//   de           data enable (active area only)
//   hblank_int   h >= H_ACTIVE
//   vblank_int   v >= V_ACTIVE
//   video_x/y    current h/v count
//   frame_start  one-clk pulse at each frame wrap
module video_timing #(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned H_ACTIVE = 360,
  parameter int unsigned H_FP     = 10,
  parameter int unsigned H_SYNC   = 10,
  parameter int unsigned H_BP     = 20,
  parameter int unsigned V_ACTIVE = 360,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  output logic       ce_pix,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       hblank_int,
  output logic       vblank_int,
  output logic [9:0] video_x,
  output logic [9:0] video_y,
  output logic       frame_start
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 10;
  // One extra bit so band limits equal to 1024 still compare correctly.
  localparam int unsigned CMP_W = CNT_W + 1;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  localparam logic [CMP_W-1:0] H_ACT_END  = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] H_SYNC_BEG = CMP_W'(H_ACTIVE + H_FP);
  localparam logic [CMP_W-1:0] H_SYNC_END = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] V_ACT_END  = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] V_SYNC_BEG = CMP_W'(V_ACTIVE + V_FP);
  localparam logic [CMP_W-1:0] V_SYNC_END = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;

  logic             w_tick;
  logic             w_h_last;
  logic             w_v_last;
  logic [CMP_W-1:0] w_h_ext;
  logic [CMP_W-1:0] w_v_ext;

  assign w_tick   = (r_div_cnt == DIV_LAST);
  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_h_ext  = {1'b0, r_h_cnt};
  assign w_v_ext  = {1'b0, r_v_cnt};

  // Divider and raster counters; restart takes priority over tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else if (restart) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Registered decodes of the current counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_pix      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      hblank_int  <= 1'b0;
      vblank_int  <= 1'b0;
      video_x     <= '0;
      video_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      ce_pix      <= w_tick;
      hsync       <= (w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END);
      vsync       <= (w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END);
      de          <= (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
      hblank_int  <= (w_h_ext >= H_ACT_END);
      vblank_int  <= (w_v_ext >= V_ACT_END);
      video_x     <= r_h_cnt;
      video_y     <= r_v_cnt;
      // A restart on the wrap cycle suppresses the frame pulse.
      frame_start <= w_tick && w_h_last && w_v_last && !restart;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
module tb_video_timing;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       restart;
  logic       ce_pix, hsync, vsync, de, hblank_int, vblank_int, frame_start;
  logic [9:0] video_x, video_y;

  int n_cmp = 0;
  int n_err = 0;
  int k     = 0;   // edges since last reset release / restart edge

  video_timing #(
    .CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart),
    .ce_pix(ce_pix), .hsync(hsync), .vsync(vsync), .de(de),
    .hblank_int(hblank_int), .vblank_int(vblank_int),
    .video_x(video_x), .video_y(video_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] obs_vec();
    return {ce_pix, frame_start, hsync, vsync, hblank_int, vblank_int, de,
            video_x, video_y};
  endfunction

  // Expected outputs after edge kk: they decode the counter state held before
  // that edge, i.e. after kk-1 free-running clocks (CLK_DIV=2, 8x6 raster).
  function automatic logic [26:0] exp_vec(input int kk);
    int s, p, h, v;
    logic c;
    s = kk - 1;
    p = s / 2;
    h = p % 8;
    v = (p / 8) % 6;
    c = (s % 2) == 1;
    return {c, c && h == 7 && v == 5, h == 5, v == 4, h >= 4, v >= 3,
            h < 4 && v < 3, 10'(h), 10'(v)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      edge1();
      chk(tag, 32'(obs_vec()), 32'(exp_vec(k)));
    end
  endtask

  int fs_cnt, vb_rise;
  logic vb_prev;

  initial begin
    reset_n = 1'b0;
    restart = 1'b0;

    // Reset: all outputs zero
    repeat (5) @(posedge clk);
    #1;
    chk("reset_all_zero", 32'(obs_vec()), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    k = 0;

    edge1();
    chk("first_edge_de", 32'(de), 32'd1);
    chk("first_edge_xy", 32'({video_x, video_y}), 32'd0);
    chk("first_edge_ce", 32'(ce_pix), 32'd0);
    chk("first_edge_blank", 32'({hblank_int, vblank_int, hsync, vsync}), 32'd0);
    edge1();
    chk("first_ce_edge2", 32'(ce_pix), 32'd1);
    chk("edge2_x", 32'(video_x), 32'd0);
    edge1();
    chk("edge3_x", 32'(video_x), 32'd1);
    chk("edge3_ce", 32'(ce_pix), 32'd0);

    // Two full frames against the raster model, plus boundary counts
    fs_cnt  = 0;
    vb_rise = 0;
    vb_prev = vblank_int;
    for (int i = 0; i < 189; i++) begin
      edge1();
      chk("frame_run", 32'(obs_vec()), 32'(exp_vec(k)));
      if (frame_start) begin
        fs_cnt++;
        chk("fs_at_x7y5", 32'({ce_pix, video_x, video_y}),
            32'({1'b1, 10'd7, 10'd5}));
      end
      if (vblank_int && !vb_prev) begin
        vb_rise++;
        chk("vb_rise_xy", 32'({video_x, video_y}), 32'({10'd0, 10'd3}));
      end
      if (!vblank_int && vb_prev)
        chk("vb_fall_y", 32'(video_y), 32'd0);
      vb_prev = vblank_int;
    end
    chk("fs_count_2frames", 32'(fs_cnt), 32'd2);
    chk("vb_rise_2frames", 32'(vb_rise), 32'd2);

    // Restart at h=6, v=2 of the third frame (state before edge 237)
    while (k < 236) run_check(1, "pre_restart");
    restart = 1'b1;
    edge1();
    chk("restart_edge_xy", 32'({video_x, video_y}), 32'({10'd6, 10'd2}));
    chk("restart_edge_fs", 32'(frame_start), 32'd0);
    restart = 1'b0;
    k = 0;
    edge1();
    chk("after_restart_xy", 32'({video_x, video_y}), 32'd0);
    chk("after_restart_fs", 32'(frame_start), 32'd0);
    chk("after_restart_ce0", 32'(ce_pix), 32'd0);
    edge1();
    chk("after_restart_ce1", 32'(ce_pix), 32'd1);
    run_check(20, "post_restart");

    // Restart on the cycle the frame pulse would fire
    while (k < 95) run_check(1, "pre_wrap");
    restart = 1'b1;
    edge1();
    chk("wrap_restart_fs", 32'(frame_start), 32'd0);
    chk("wrap_restart_xy", 32'({video_x, video_y}), 32'({10'd7, 10'd5}));
    restart = 1'b0;
    k = 0;
    edge1();
    chk("wrap_restart_after_xy", 32'({video_x, video_y}), 32'd0);
    chk("wrap_restart_after_fs", 32'(frame_start), 32'd0);
    run_check(30, "post_wrap_restart");

    // Held restart keeps counters at zero
    restart = 1'b1;
    edge1();
    edge1();
    chk("held_restart_xy", 32'({video_x, video_y}), 32'd0);
    edge1();
    chk("held_restart_ce", 32'(ce_pix), 32'd0);
    restart = 1'b0;
    k = 0;
    run_check(10, "post_held_restart");

    // Asynchronous reset mid-frame at y=4
    while (k < 70) run_check(1, "pre_async");
    chk("pre_async_vsync", 32'({vsync, vblank_int, video_y}),
        32'({1'b1, 1'b1, 10'd4}));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_vsync_vb_y", 32'({vsync, vblank_int, video_y}), 32'd0);
    chk("async_all_zero", 32'(obs_vec()), 32'd0);
    edge1();
    edge1();
    chk("async_held_zero", 32'(obs_vec()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    run_check(24, "post_async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
